// File: rtl/seq_det_param_disp_if.sv
// Bus bundle for seq_det_param_disp: serial input, pattern control, match status and 7-seg pins.
interface seq_det_param_disp_if #(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned CNT_W = 16
);
   logic             bit_in;
   logic             bit_vld;
   logic [PAT_W-1:0] pat_in;
   logic             pat_load;
   logic             overlap;
   logic             cnt_clr;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic             cnt_sat;
   logic [3:0]       dig;
   logic [7:0]       smg;

   modport master (
      output bit_in, bit_vld, pat_in, pat_load, overlap, cnt_clr,
      input  match, match_cnt, cnt_sat, dig, smg
   );

   modport slave (
      input  bit_in, bit_vld, pat_in, pat_load, overlap, cnt_clr,
      output match, match_cnt, cnt_sat, dig, smg
   );
endinterface

// File: rtl/seq_det_param_disp.sv
// Serial pattern detector with saturating match counter and 4-digit multiplexed hex 7-seg driver.
// Optional build macro LEAD_ZERO_BLANK_EN blanks digits above the highest nonzero digit.
module seq_det_param_disp #(
   parameter int unsigned PAT_W    = 8,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned SCAN_DIV = 500
) (
   input  logic                   clk,
   input  logic                   rst,
   seq_det_param_disp_if.slave    bus
);

   localparam int unsigned FILL_W = $clog2(PAT_W + 1);
   localparam int unsigned DIV_W  = $clog2(SCAN_DIV);

   // Active-low segment codes {dp,g,f,e,d,c,b,a}, dp held off.
   function automatic logic [7:0] hex7(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'h0:    s = 8'hC0;
         4'h1:    s = 8'hF9;
         4'h2:    s = 8'hA4;
         4'h3:    s = 8'hB0;
         4'h4:    s = 8'h99;
         4'h5:    s = 8'h92;
         4'h6:    s = 8'h82;
         4'h7:    s = 8'hF8;
         4'h8:    s = 8'h80;
         4'h9:    s = 8'h90;
         4'hA:    s = 8'h88;
         4'hB:    s = 8'h83;
         4'hC:    s = 8'hC6;
         4'hD:    s = 8'hA1;
         4'hE:    s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   logic [PAT_W-1:0]  pat_reg, pat_reg_n;
   logic [PAT_W-1:0]  hist, hist_n, hist_shift;
   logic [FILL_W-1:0] fill, fill_n, fill_inc;
   logic              match_q, match_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;
   logic              sat_q, sat_n;
   logic [DIV_W-1:0]  div_q, div_n;
   logic              scan_tick;
   logic [1:0]        idx_q, idx_n;
   logic [3:0]        dig_q, dig_n;
   logic [7:0]        smg_q, smg_n;
   logic [15:0]       cnt16;
   logic [3:0]        nib;
   logic              blank;

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_reg <= '0;
         hist    <= '0;
         fill    <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         div_q   <= '0;
         idx_q   <= 2'd0;
         dig_q   <= 4'b1111;
         smg_q   <= 8'hFF;
      end else begin
         pat_reg <= pat_reg_n;
         hist    <= hist_n;
         fill    <= fill_n;
         match_q <= match_n;
         cnt_q   <= cnt_n;
         sat_q   <= sat_n;
         div_q   <= div_n;
         idx_q   <= idx_n;
         dig_q   <= dig_n;
         smg_q   <= smg_n;
      end
   end

   // Detector: fill < PAT_W is filling, fill == PAT_W is armed
   always_comb begin
      pat_reg_n  = pat_reg;
      hist_n     = hist;
      fill_n     = fill;
      match_n    = 1'b0;
      hist_shift = {hist[PAT_W-2:0], bus.bit_in};
      fill_inc   = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
      if (bus.pat_load) begin
         pat_reg_n = bus.pat_in;
         hist_n    = '0;
         fill_n    = '0;
      end else if (bus.bit_vld) begin
         hist_n = hist_shift;
         fill_n = fill_inc;
         if ((fill_inc == FILL_W'(PAT_W)) && (hist_shift == pat_reg)) begin
            match_n = 1'b1;
            // Non-overlapping mode demands a full window of fresh bits
            if (!bus.overlap) fill_n = '0;
         end
      end
   end

   // Saturating match counter; clear wins over a same-cycle increment
   always_comb begin
      cnt_n = cnt_q;
      if (bus.cnt_clr)
         cnt_n = '0;
      else if (match_q && !(&cnt_q))
         cnt_n = cnt_q + CNT_W'(1);
      sat_n = &cnt_n;
   end

   // Digit scan: divider tick advances the digit and loads its segments
   always_comb begin
      div_n     = div_q;
      idx_n     = idx_q;
      dig_n     = dig_q;
      smg_n     = smg_q;
      scan_tick = (div_q == DIV_W'(SCAN_DIV - 1));
      cnt16     = 16'(cnt_q);
      nib       = 4'h0;
      blank     = 1'b0;
      if (scan_tick) begin
         div_n = '0;
         idx_n = idx_q + 2'd1;
      end else begin
         div_n = div_q + DIV_W'(1);
      end
      nib = cnt16[{idx_n, 2'b00} +: 4];
`ifdef LEAD_ZERO_BLANK_EN
      case (idx_n)
         2'd1:    blank = (cnt16[15:4]  == 12'h000);
         2'd2:    blank = (cnt16[15:8]  == 8'h00);
         2'd3:    blank = (cnt16[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
`else
      blank = 1'b0;
`endif
      if (scan_tick) begin
         dig_n = ~(4'b0001 << idx_n);
         smg_n = blank ? 8'hFF : hex7(nib);
      end
   end

   assign bus.match     = match_q;
   assign bus.match_cnt = cnt_q;
   assign bus.cnt_sat   = sat_q;
   assign bus.dig       = dig_q;
   assign bus.smg       = smg_q;

endmodule
